// File: rtl/prach_sym_framer.sv
// PRACH symbol framer: per-channel beat/symbol counting on the time-interleaved reshape stream,
// tagging accepted beats with sop/eop/symbol index and flagging dropped beats.
module prach_sym_framer #(
  parameter int unsigned NumChn = 8,
  parameter int unsigned SymLen = 1536,
  parameter int unsigned NumSym = 12
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] din_dp1_i,
  input  logic [15:0] din_dp2_i,
  input  logic        din_dv_i,
  input  logic [7:0]  din_chn_i,
  input  logic        sync_in_i,
  output logic [15:0] dout_dp1_o,
  output logic [15:0] dout_dp2_o,
  output logic        dout_dv_o,
  output logic [7:0]  dout_chn_o,
  output logic        dout_sop_o,
  output logic        dout_eop_o,
  output logic [3:0]  dout_sym_o,
  output logic        sync_out_o,
  output logic        frame_done_o,
  output logic        err_chn_o,
  output logic        err_ovf_o
);

  localparam int unsigned BeatW = $clog2(SymLen);
  localparam int unsigned IdxW  = (NumChn > 1) ? $clog2(NumChn) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e state_q, state_d;

  logic [BeatW-1:0]  beat_q [NumChn];
  logic [3:0]        sym_q  [NumChn];
  logic [NumChn-1:0] done_q, done_d, done_cur;

  logic [IdxW-1:0]  idx;
  logic             chn_ok, active, rd_done, accept, is_eop, is_last, frame_fin;
  logic [BeatW-1:0] rd_beat;
  logic [3:0]       rd_sym;

  logic [15:0] dp1_d, dp2_d, dp1_q, dp2_q;
  logic [7:0]  chn_d, chn_q;
  logic [3:0]  sym_d, sym_out_q;
  logic        dv_d, dv_q, sop_d, sop_q, eop_d, eop_q, sync_d, sync_q;
  logic        fdone_d, fdone_q, echn_d, echn_q, eovf_d, eovf_q;

  // A sync on this cycle makes the beat see freshly cleared counters.
  always_comb begin
    idx      = din_chn_i[IdxW-1:0];
    chn_ok   = {1'b0, din_chn_i} < 9'(NumChn);
    active   = sync_in_i || (state_q == StRun);
    rd_beat  = sync_in_i ? '0 : beat_q[idx];
    rd_sym   = sync_in_i ? '0 : sym_q[idx];
    done_cur = sync_in_i ? '0 : done_q;
    rd_done  = done_cur[idx];
    accept   = din_dv_i && active && chn_ok && !rd_done;
    is_eop   = (rd_beat == BeatW'(SymLen - 1));
    is_last  = (rd_sym == 4'(NumSym - 1));
    done_d   = done_cur;
    if (accept && is_eop && is_last) begin
      done_d[idx] = 1'b1;
    end
    frame_fin = accept && is_eop && is_last && (&done_d);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (sync_in_i) begin
      state_d = StRun;
    end else if (frame_fin) begin
      state_d = StIdle;
    end
  end

  always_comb begin
    dp1_d   = din_dp1_i;
    dp2_d   = din_dp2_i;
    chn_d   = din_chn_i;
    sync_d  = sync_in_i;
    dv_d    = accept;
    sop_d   = accept && (rd_beat == '0);
    eop_d   = accept && is_eop;
    sym_d   = accept ? rd_sym : 4'd0;
    fdone_d = frame_fin;
    echn_d  = din_dv_i && active && !chn_ok;
    eovf_d  = din_dv_i && (!active || (chn_ok && rd_done));
  end

  // Single read-modify-write per cycle; the accepted write lands after any sync clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumChn); i++) begin
        beat_q[i] <= '0;
        sym_q[i]  <= '0;
      end
      done_q <= '0;
    end else begin
      if (sync_in_i) begin
        for (int i = 0; i < int'(NumChn); i++) begin
          beat_q[i] <= '0;
          sym_q[i]  <= '0;
        end
      end
      done_q <= done_d;
      if (accept) begin
        beat_q[idx] <= is_eop ? '0 : rd_beat + BeatW'(1);
        sym_q[idx]  <= (is_eop && !is_last) ? rd_sym + 4'd1 : rd_sym;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      dp1_q     <= '0;
      dp2_q     <= '0;
      chn_q     <= '0;
      sync_q    <= 1'b0;
      dv_q      <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      sym_out_q <= '0;
      fdone_q   <= 1'b0;
      echn_q    <= 1'b0;
      eovf_q    <= 1'b0;
    end else begin
      dp1_q     <= dp1_d;
      dp2_q     <= dp2_d;
      chn_q     <= chn_d;
      sync_q    <= sync_d;
      dv_q      <= dv_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      sym_out_q <= sym_d;
      fdone_q   <= fdone_d;
      echn_q    <= echn_d;
      eovf_q    <= eovf_d;
    end
  end

  assign dout_dp1_o   = dp1_q;
  assign dout_dp2_o   = dp2_q;
  assign dout_chn_o   = chn_q;
  assign dout_dv_o    = dv_q;
  assign dout_sop_o   = sop_q;
  assign dout_eop_o   = eop_q;
  assign dout_sym_o   = sym_out_q;
  assign sync_out_o   = sync_q;
  assign frame_done_o = fdone_q;
  assign err_chn_o    = echn_q;
  assign err_ovf_o    = eovf_q;

endmodule

// File: tb/tb_prach_sym_framer.sv
// Scoreboard bench for prach_sym_framer: driver pushes expected outputs per cycle from a
// per-channel beat-count model, a monitor pops and compares one cycle later.
module tb_prach_sym_framer;

  localparam int unsigned NumChn = 2;
  localparam int unsigned SymLen = 4;
  localparam int unsigned NumSym = 2;
  localparam int unsigned Total  = SymLen * NumSym;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din_dp1 = '0, din_dp2 = '0;
  logic        din_dv = 1'b0;
  logic [7:0]  din_chn = '0;
  logic        sync_in = 1'b0;
  logic [15:0] dout_dp1, dout_dp2;
  logic        dout_dv, dout_sop, dout_eop, sync_out, frame_done, err_chn, err_ovf;
  logic [7:0]  dout_chn;
  logic [3:0]  dout_sym;

  always #5 clk = ~clk;

  prach_sym_framer #(.NumChn(NumChn), .SymLen(SymLen), .NumSym(NumSym)) dut (
    .clk_i(clk), .rst_ni(rst_n), .din_dp1_i(din_dp1), .din_dp2_i(din_dp2), .din_dv_i(din_dv),
    .din_chn_i(din_chn), .sync_in_i(sync_in), .dout_dp1_o(dout_dp1), .dout_dp2_o(dout_dp2),
    .dout_dv_o(dout_dv), .dout_chn_o(dout_chn), .dout_sop_o(dout_sop), .dout_eop_o(dout_eop),
    .dout_sym_o(dout_sym), .sync_out_o(sync_out), .frame_done_o(frame_done),
    .err_chn_o(err_chn), .err_ovf_o(err_ovf)
  );

  typedef struct packed {
    logic        dv, sop, eop;
    logic [3:0]  sym;
    logic [7:0]  chn;
    logic [15:0] dp1, dp2;
    logic        sync_o, fdone, echn, eovf;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   fd_seen = 0;

  bit m_run = 1'b0;
  int m_cnt [NumChn];

  task automatic step(input logic rn, input logic dv, input logic [7:0] ch, input logic sy);
    obs_t e;
    bit   all_done;
    @(posedge clk);
    #1;
    rst_n   = rn;
    din_dv  = dv;
    din_chn = ch;
    sync_in = sy;
    din_dp1 = 16'($urandom);
    din_dp2 = 16'($urandom);
    e = '0;
    if (!rn) begin
      m_run = 1'b0;
      for (int i = 0; i < int'(NumChn); i++) m_cnt[i] = 0;
    end else begin
      e.dp1 = din_dp1;
      e.dp2 = din_dp2;
      e.chn = ch;
      e.sync_o = sy;
      if (sy) begin
        m_run = 1'b1;
        for (int i = 0; i < int'(NumChn); i++) m_cnt[i] = 0;
      end
      if (dv) begin
        if (!m_run) e.eovf = 1'b1;
        else if (int'(ch) >= int'(NumChn)) e.echn = 1'b1;
        else if (m_cnt[ch] == int'(Total)) e.eovf = 1'b1;
        else begin
          e.dv  = 1'b1;
          e.sop = (m_cnt[ch] % SymLen) == 0;
          e.eop = (m_cnt[ch] % SymLen) == SymLen - 1;
          e.sym = 4'(m_cnt[ch] / SymLen);
          m_cnt[ch]++;
          all_done = 1'b1;
          for (int i = 0; i < int'(NumChn); i++) if (m_cnt[i] != int'(Total)) all_done = 1'b0;
          if (all_done) begin
            e.fdone = 1'b1;
            m_run = 1'b0;
          end
        end
      end
    end
    exp_q.push_back(e);
  endtask

  always begin
    obs_t e, a;
    bit   bad;
    @(posedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      a = '{dout_dv, dout_sop, dout_eop, dout_sym, dout_chn, dout_dp1, dout_dp2,
            sync_out, frame_done, err_chn, err_ovf};
      if (a.fdone) fd_seen++;
      bad = (a.dv != e.dv) || (a.chn != e.chn) || (a.dp1 != e.dp1) || (a.dp2 != e.dp2) ||
            (a.sync_o != e.sync_o) || (a.fdone != e.fdone) || (a.echn != e.echn) ||
            (a.eovf != e.eovf) ||
            (e.dv && ((a.sop != e.sop) || (a.eop != e.eop) || (a.sym != e.sym)));
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL out@%0t got dv=%b sop=%b eop=%b sym=%0d chn=%0d dp=%h/%h so=%b fd=%b ec=%b eo=%b want dv=%b sop=%b eop=%b sym=%0d chn=%0d dp=%h/%h so=%b fd=%b ec=%b eo=%b",
                 $time, a.dv, a.sop, a.eop, a.sym, a.chn, a.dp1, a.dp2, a.sync_o, a.fdone,
                 a.echn, a.eovf, e.dv, e.sop, e.eop, e.sym, e.chn, e.dp1, e.dp2, e.sync_o,
                 e.fdone, e.echn, e.eovf);
      end
    end
  end

  // chn0 reaches its 8th beat at index 14, two extra chn0 beats follow, chn1 closes the frame
  // at index 17, index 18 arrives with the block back in idle.
  logic [7:0] frame_seq [19] = '{8'd1, 8'd0, 8'd1, 8'd0, 8'd5, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1,
                                 8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1};

  initial begin
    for (int i = 0; i < int'(NumChn); i++) m_cnt[i] = 0;
    repeat (3) step(1'b0, 1'b1, 8'd0, 1'b1);
    repeat (3) step(1'b1, 1'b1, 8'd0, 1'b0);
    step(1'b1, 1'b0, 8'd0, 1'b0);

    step(1'b1, 1'b1, 8'd0, 1'b1);
    for (int i = 0; i < 19; i++) step(1'b1, 1'b1, frame_seq[i], 1'b0);
    repeat (3) step(1'b1, 1'b0, 8'd0, 1'b0);
    checks++;
    if (fd_seen != 1) begin
      errors++;
      $display("FAIL frame_done_count got %0d want 1", fd_seen);
    end

    step(1'b1, 1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'(i % 2), 1'b0);
    repeat (2) step(1'b0, 1'b1, 8'd0, 1'b0);
    step(1'b1, 1'b1, 8'd0, 1'b0);
    step(1'b1, 1'b1, 8'd0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 8'(i % 2), 1'b0);

    step(1'b1, 1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 7),
           8'($urandom_range(0, 9) < 9 ? $urandom_range(0, 1) : $urandom_range(2, 255)),
           ($urandom_range(0, 59) == 0));
    end

    repeat (3) step(1'b1, 1'b0, 8'd0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prach_sym_framer.md
Name: prach_sym_framer

Overview:
- Downstream stage of the 64-point PRACH reshape.
- Consumes the reshaped sample-pair stream, which is time-interleaved across channels.
- Keeps one sample/symbol counter per channel and tags each accepted beat with start-of-symbol, end-of-symbol and symbol index, so the FFT loader can frame each channel's PRACH symbols.
- Beats before the first sync, beats beyond the last symbol, and beats on invalid channels are dropped and flagged.

Parameters:
NUM_CHN, 8, number of valid channel indices (0..NUM_CHN-1), 1..256
SYM_LEN, 1536, beats per symbol per channel, >=2
NUM_SYM, 12, symbols per frame per channel, 1..16

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
din_dp1  in  16  packed sample word 1 from reshape
din_dp2  in  16  packed sample word 2 from reshape
din_dv  in  1  input beat valid
din_chn  in  8  channel index of beat
sync_in  in  1  frame-start pulse, one cycle
dout_dp1  out  16  registered din_dp1
dout_dp2  out  16  registered din_dp2
dout_dv  out  1  accepted beat valid
dout_chn  out  8  channel of accepted beat
dout_sop  out  1  first beat of a symbol (qualified by dout_dv)
dout_eop  out  1  last beat of a symbol (qualified by dout_dv)
dout_sym  out  4  symbol index of beat, 0..NUM_SYM-1
sync_out  out  1  sync_in delayed 1 cycle
frame_done  out  1  one-cycle pulse when all channels have completed NUM_SYM symbols
err_chn  out  1  one-cycle pulse: beat with din_chn >= NUM_CHN
err_ovf  out  1  one-cycle pulse: beat for a finished channel, or a beat while IDLE

Behaviour:
- Reset (rst_n low at a clk edge):
  - All outputs are 0; state is IDLE.
  - All per-channel counters and done flags are cleared.
  - Reset mid-frame discards progress; the block then waits for a new sync.
- Latency:
  - All outputs are registered, 1 cycle from input.
  - dout_dp1/dp2/chn follow the inputs every cycle; downstream qualifies them with dout_dv.
  - sync_out = sync_in delayed 1 cycle, in every state.
- Per-channel state:
  - beat counter, 0..SYM_LEN-1
  - symbol counter, 0..NUM_SYM-1
  - done flag
- State machine:
  - IDLE: beats are not accepted; dout_dv=0; err_ovf pulses for each din_dv. sync_in -> RUN.
  - RUN: beats are processed as described below. When the last channel's done flag sets -> IDLE, with frame_done pulsed on the same output cycle as that channel's final eop.
  - sync_in in any state clears all counters and done flags and enters RUN.
- sync_in coincident with din_dv: counters clear first, and the beat is processed as beat 0, symbol 0 of its channel.
- Beat processing in RUN, din_dv=1, channel c = din_chn:
  - c >= NUM_CHN: dropped, dout_dv=0, err_chn=1. No counter changes.
  - done[c]=1: dropped, dout_dv=0, err_ovf=1.
  - Otherwise accepted:
    - dout_dv=1, dout_sym = sym[c].
    - dout_sop = (beat[c]==0).
    - dout_eop = (beat[c]==SYM_LEN-1).
    - On eop: beat[c] wraps to 0, sym[c] increments. If sym[c]==NUM_SYM-1, done[c] is set instead and sym[c] holds.
    - Otherwise beat[c] increments.
- Channel independence: channels may interleave in any order and at any rate; each channel's counters advance only on its own accepted beats.
- din_dv=0: no counter change, dout_dv=0, no error pulses.
- SYM_LEN=1 is not supported; sop and eop are never set on the same beat.
- Counter widths: $clog2(SYM_LEN) bits and 4 bits. Counters are stored in per-channel register arrays, with a single read-modify-write per cycle (only one channel is active per beat).

Test Plan:
- NUM_CHN=2, SYM_LEN=4, NUM_SYM=2:
  - Reset, then sync, then 16 beats alternating chn 0,1 -> each channel shows sop at beats 0 and 4, eop at beats 3 and 7, dout_sym 0,0,0,0,1,1,1,1. frame_done pulses once, on the cycle after chn 1's 8th beat. sync_out follows sync_in by 1 cycle.
- 3 beats before any sync -> dout_dv stays 0, err_ovf pulses 3 times.
- sync_in on the same cycle as a chn 0 beat -> that beat exits with sop=1, sym=0 one cycle later.
- Beat with din_chn=5 mid-frame -> err_chn pulses, dout_dv=0, and the channel 0/1 sequence continues unaffected.
- After chn 0 completes, 2 more chn 0 beats -> both dropped with err_ovf, while chn 1 still progresses normally.
- rst_n low after 5 beats, then a new sync -> the next chn 0 beat restarts at sop=1, sym=0 and all outputs were 0 during reset. Repeat with default parameters and random interleaving and idle gaps, scoreboarding sop/eop positions against per-channel counts.
